// File: rtl/lpc_io_host.sv
// LPC host issuing I/O read/write cycles with SYNC wait-state handling and timeout.
// Define LPC_HOST_ABORT_EN to emit an abort frame (LFRAME# low, LAD=F x4) on timeout.
module lpc_io_host #(
    parameter int SYNC_TIMEOUT  = 8,
    parameter int LONG_WAIT_MAX = 1024,
    parameter int IDLE_GAP      = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_status,
    output logic        lpc_lframe_n,
    output logic [3:0]  lad_o,
    output logic        lad_oe,
    input  logic [3:0]  lad_i
);
    localparam int              WW     = $clog2(LONG_WAIT_MAX + 1);
    localparam logic [WW-1:0]   LIM_S  = WW'(SYNC_TIMEOUT);
    localparam logic [WW-1:0]   LIM_L  = WW'(LONG_WAIT_MAX);
    localparam logic [3:0]      GAP_LD = 4'(IDLE_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_HTAR, S_SYNC, S_RDATA, S_PTAR,
`ifdef LPC_HOST_ABORT_EN
        S_ABORT,
`endif
        S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    logic [WW-1:0]   r_wait, w_wait_nxt, w_wait_inc, w_limit;
    logic            r_long, w_long_nxt;
    logic [1:0]      r_stat, w_stat_nxt;
    logic [7:0]      r_rdata, w_rdata_nxt;
    logic            r_write, w_write_nxt;
    logic [15:0]     r_addr, w_addr_nxt;
    logic [7:0]      r_wdata, w_wdata_nxt;
    logic [3:0]      r_gap, w_gap_nxt;

    logic            r_cmd_ready, w_ready_nxt;
    logic            r_rsp_valid, w_rvalid_nxt;
    logic [7:0]      r_rsp_data, w_rspdata_nxt;
    logic [1:0]      r_rsp_status, w_rspstat_nxt;
    logic            r_lframe_n, w_lframe_nxt;
    logic [3:0]      r_lad_o, w_lad_nxt;
    logic            r_lad_oe, w_oe_nxt;

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_status   = r_rsp_status;
    assign lpc_lframe_n = r_lframe_n;
    assign lad_o        = r_lad_o;
    assign lad_oe       = r_lad_oe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wait       <= '0;
            r_long       <= 1'b0;
            r_stat       <= 2'b00;
            r_rdata      <= 8'h00;
            r_write      <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 8'h00;
            r_gap        <= 4'h0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_rsp_status <= 2'b00;
            r_lframe_n   <= 1'b1;
            r_lad_o      <= 4'hF;
            r_lad_oe     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wait       <= w_wait_nxt;
            r_long       <= w_long_nxt;
            r_stat       <= w_stat_nxt;
            r_rdata      <= w_rdata_nxt;
            r_write      <= w_write_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_gap        <= w_gap_nxt;
            r_cmd_ready  <= w_ready_nxt;
            r_rsp_valid  <= w_rvalid_nxt;
            r_rsp_data   <= w_rspdata_nxt;
            r_rsp_status <= w_rspstat_nxt;
            r_lframe_n   <= w_lframe_nxt;
            r_lad_o      <= w_lad_nxt;
            r_lad_oe     <= w_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait;
        w_long_nxt  = r_long;
        w_stat_nxt  = r_stat;
        w_rdata_nxt = r_rdata;
        w_write_nxt = r_write;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_gap_nxt   = r_gap;
        w_wait_inc  = r_wait + 1'b1;
        // A long-wait nibble extends the limit from the very cycle it is seen
        w_limit     = (r_long || lad_i == 4'b0110) ? LIM_L : LIM_S;

        case (r_state)
            S_IDLE: begin
                if (r_gap != 4'h0) w_gap_nxt = r_gap - 4'h1;
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt = S_START;
                    w_write_nxt = cmd_write;
                    w_addr_nxt  = cmd_addr;
                    w_wdata_nxt = cmd_data;
                    w_stat_nxt  = 2'b00;
                    w_rdata_nxt = 8'h00;
                end
            end
            S_START:   w_state_nxt = S_CYCTYPE;
            S_CYCTYPE: begin
                w_state_nxt = S_ADDR;
                w_cnt_nxt   = 3'd0;
            end
            S_ADDR: begin
                if (r_cnt == 3'd3) begin
                    w_state_nxt = r_write ? S_WDATA : S_HTAR;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_WDATA: begin
                if (r_cnt[0]) begin
                    w_state_nxt = S_HTAR;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_HTAR: begin
                if (r_cnt[0]) begin
                    w_state_nxt = S_SYNC;
                    w_wait_nxt  = '0;
                    w_long_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_SYNC: begin
                case (lad_i)
                    4'b0000: begin
                        w_state_nxt = r_write ? S_PTAR : S_RDATA;
                        w_cnt_nxt   = 3'd0;
                    end
                    4'b1010: begin
                        w_stat_nxt  = 2'b01;
                        w_state_nxt = S_PTAR;
                        w_cnt_nxt   = 3'd0;
                    end
                    default: begin
                        w_wait_nxt = w_wait_inc;
                        if (lad_i == 4'b0110) w_long_nxt = 1'b1;
                        if (w_wait_inc >= w_limit) begin
                            w_stat_nxt = 2'b10;
`ifdef LPC_HOST_ABORT_EN
                            w_state_nxt = S_ABORT;
                            w_cnt_nxt   = 3'd0;
`else
                            w_state_nxt = S_DONE;
`endif
                        end
                    end
                endcase
            end
            S_RDATA: begin
                if (r_cnt[0]) begin
                    w_rdata_nxt[7:4] = lad_i;
                    w_state_nxt      = S_PTAR;
                    w_cnt_nxt        = 3'd0;
                end else begin
                    w_rdata_nxt[3:0] = lad_i;
                    w_cnt_nxt        = r_cnt + 3'd1;
                end
            end
            S_PTAR: begin
                if (r_cnt[0]) w_state_nxt = S_DONE;
                else          w_cnt_nxt   = r_cnt + 3'd1;
            end
`ifdef LPC_HOST_ABORT_EN
            S_ABORT: begin
                if (r_cnt == 3'd4) w_state_nxt = S_DONE;
                else               w_cnt_nxt   = r_cnt + 3'd1;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gap_nxt   = GAP_LD;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they land registered
        w_lframe_nxt = 1'b1;
        w_oe_nxt     = 1'b0;
        w_lad_nxt    = 4'hF;
        case (w_state_nxt)
            S_START: begin
                w_lframe_nxt = 1'b0;
                w_oe_nxt     = 1'b1;
                w_lad_nxt    = 4'h0;
            end
            S_CYCTYPE: begin
                w_oe_nxt  = 1'b1;
                w_lad_nxt = w_write_nxt ? 4'b0010 : 4'b0000;
            end
            S_ADDR: begin
                w_oe_nxt = 1'b1;
                case (w_cnt_nxt[1:0])
                    2'd0:    w_lad_nxt = w_addr_nxt[15:12];
                    2'd1:    w_lad_nxt = w_addr_nxt[11:8];
                    2'd2:    w_lad_nxt = w_addr_nxt[7:4];
                    default: w_lad_nxt = w_addr_nxt[3:0];
                endcase
            end
            S_WDATA: begin
                w_oe_nxt  = 1'b1;
                w_lad_nxt = w_cnt_nxt[0] ? w_wdata_nxt[7:4] : w_wdata_nxt[3:0];
            end
            S_HTAR: w_oe_nxt = ~w_cnt_nxt[0];
`ifdef LPC_HOST_ABORT_EN
            S_ABORT: begin
                if (w_cnt_nxt != 3'd4) begin
                    w_lframe_nxt = 1'b0;
                    w_oe_nxt     = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        w_ready_nxt   = (w_state_nxt == S_IDLE) && (w_gap_nxt == 4'h0);
        w_rvalid_nxt  = (w_state_nxt == S_DONE);
        w_rspdata_nxt = r_rsp_data;
        w_rspstat_nxt = r_rsp_status;
        if (w_state_nxt == S_DONE) begin
            w_rspstat_nxt = w_stat_nxt;
            w_rspdata_nxt = (w_stat_nxt == 2'b00 && !r_write) ? w_rdata_nxt : 8'h00;
        end
    end
endmodule

// File: doc/lpc_io_host.md
# lpc_io_host

Synthesizable LPC host that issues I/O read and I/O write cycles on the card's LPC port. It is the bench-free, parametrised successor to the scripted port-0x80 write stimulus. It supports reads and writes to any 16-bit I/O address, SYNC wait-state handling, a timeout, and an optional abort frame. It sits beside the LPC capture path for loopback self-test and for driving external LPC peripherals from on-card logic.

## Interface
- SYNC_TIMEOUT, 8: maximum consecutive SYNC cycles with no valid SYNC (or with short-wait 0101) before a timeout.
- LONG_WAIT_MAX, 1024: maximum SYNC cycles once long-wait 0110 has been seen.
- IDLE_GAP, 1: minimum number of idle cycles (LFRAME# high, LAD undriven) between transactions; range 1..15.

Ports:
- clk  in  1  LPC clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with the gap expired.
- cmd_write  in  1  1 = I/O write, 0 = I/O read.
- cmd_addr  in  16  I/O address.
- cmd_data  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  8  read data (0x00 for writes and failures).
- rsp_status  out  2  00 ok, 01 SYNC error (1010), 10 timeout.
- lpc_lframe_n  out  1  LFRAME#.
- lad_o  out  4  LAD output value.
- lad_oe  out  1  LAD output enable.
- lad_i  in  4  LAD sampled value.

## Operation
- Reset values: lpc_lframe_n=1, lad_o=4'hF, lad_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_status=0.
- Command accept: a handshake is cmd_valid & cmd_ready. The command is latched on that edge; the first bus cycle follows on the next edge.
- States: IDLE, START, CYCTYPE, ADDR(4), WDATA(2), HTAR(2), SYNC, RDATA(2), PTAR(2), ABORT(4, macro only), DONE.
- START: lframe_n=0, lad_o=0000, oe=1.
- CYCTYPE: lframe_n=1; lad_o=0010 for a write, 0000 for a read.
- ADDR: address nibbles in order addr[15:12], [11:8], [7:4], [3:0].
- WDATA (writes only): data[3:0] first, then data[7:4].
- HTAR: cycle 1 drives lad_o=1111 with oe=1; cycle 2 has oe=0.
- SYNC: oe=0 and lad_i is sampled every cycle.
  - 0000 moves to RDATA for a read, or to PTAR for a write.
  - 1010 sets status 01 and moves to PTAR.
  - 0110 switches the active limit to LONG_WAIT_MAX.
  - Any other value increments the wait counter.
  - When the counter reaches the active limit, the block moves to timeout handling.
- RDATA: lad_i is captured LSN first into rsp_data.
- PTAR: 2 cycles with oe=0, then DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. The IDLE_GAP counter starts in IDLE; cmd_ready rises once it expires.
- Timeout without the macro: status 10, then directly to DONE; no PTAR, no abort.
- rsp_data and rsp_status hold until the next rsp_valid.
- cmd_valid outside IDLE is ignored. No queuing; the caller holds the command.
- Reset asserted mid-transaction: all outputs return to reset values immediately and asynchronously, with no abort frame; any response in flight is lost.

## Timing
- Write with zero-wait SYNC: 13 bus cycles from START to the end of PTAR; rsp_valid on the 14th cycle after START.
- Read: same count, with RDATA in place of WDATA.
- Each SYNC wait cycle adds one cycle.
- Earliest back-to-back START: DONE + IDLE_GAP + 1 cycles after the previous DONE.
- All outputs are registered; no combinational path from lad_i to any output.

## Configuration
- LPC_HOST_ABORT_EN defined: on timeout, the block enters ABORT.
  - ABORT drives lframe_n=0 with lad_o=1111 and oe=1 for 4 cycles.
  - Then 1 cycle with lframe_n=1 and oe=0, then DONE with status 10.
- LPC_HOST_ABORT_EN undefined: ABORT is not built; timeout goes straight to DONE as described in Operation.

## Test plan
- Write 0x0080 ← 0x5A, peripheral SYNC 0000 at the first SYNC cycle:
  - LAD sequence 0,2,0,0,8,0,A,5,F,Z.
  - rsp_valid 14 cycles after START with status 00.
- Read 0x03F8, SYNC 0101 ×3 then 0000, data nibbles 4 then C: rsp_data=0xC4, status 00, and rsp_valid 3 cycles later than the zero-wait case.
- Write, SYNC 0110 for 20 cycles then 0000: no timeout, status 00.
- Write, SYNC 1010: status 01, PTAR executed, rsp_data=0x00.
- Write with LAD floating (lad_i=1111) for the whole SYNC phase:
  - Timeout after 8 cycles, status 10.
  - With LPC_HOST_ABORT_EN, lframe_n is low for 4 cycles with lad_o=F before rsp_valid; without it, lframe_n is never low after START.
- reset_n pulsed low during ADDR: lframe_n=1, oe=0 and cmd_ready=1 within the same cycle; no rsp_valid; the next command completes normally.
